// File: rtl/seq_divider_if.sv
// Request/result handshake bundle for seq_divider: operands in, quotient/remainder out.
// The divider takes the slave side; the requester/consumer takes master.
interface seq_divider_if #(
  parameter int n = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic         ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] Q;
  logic [n-1:0] R;
  logic         div_by_zero;

  modport master (
    output in_valid, A, B, ctrl, out_ready,
    input  in_ready, out_valid, Q, R, div_by_zero
  );

  modport slave (
    input  in_valid, A, B, ctrl, out_ready,
    output in_ready, out_valid, Q, R, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, unsigned or signed (ctrl); SEQ_DIVIDER_ZERO_CHECK_EN adds a B==0 early-out.
// Result valid n+1 edges after acceptance (1 edge on zero early-out); result held in DONE while out_ready is low.
module seq_divider #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave io
);
  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sgn_q, sgn_d;
  logic          a_neg_q, a_neg_d;
  logic          b_neg_q, b_neg_d;
  logic [n-1:0]  dvsr_q, dvsr_d;
  logic [n-1:0]  rem_q, rem_d;
  logic [n-1:0]  quo_q, quo_d;
  logic [n-1:0]  q_q, q_d;
  logic [n-1:0]  r_q, r_d;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  logic          zflag_q, zflag_d;
  logic          dbz_q, dbz_d;
  logic          b_zero;
`endif

  logic          in_ready;
  logic          accept;
  logic          a_neg_in, b_neg_in;
  logic [n-1:0]  a_mag, b_mag;
  logic [n:0]    shifted;
  logic [n-1:0]  diff;
  logic          borrow;

  function automatic logic [n-1:0] neg(input logic [n-1:0] v);
    return ~v + 1'b1;
  endfunction

  assign accept   = io.in_valid & in_ready;
  assign a_neg_in = io.ctrl & io.A[n-1];
  assign b_neg_in = io.ctrl & io.B[n-1];
  assign a_mag    = a_neg_in ? neg(io.A) : io.A;
  assign b_mag    = b_neg_in ? neg(io.B) : io.B;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  assign b_zero   = (io.B == '0);
`endif

  // Trial subtract: borrow out of the n+1 bit difference means "restore".
  // Only the low n bits of a kept difference matter since it is below the divisor.
  assign shifted = {rem_q, quo_q[n-1]};
  assign borrow  = (shifted < {1'b0, dvsr_q});
  assign diff    = shifted[n-1:0] - dvsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
          state_d = b_zero ? FIX : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC:    if (cnt_q == CW'(n - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == IDLE);
    io.in_ready  = in_ready;
    io.out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    dvsr_d  = dvsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    zflag_d = zflag_q;
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sgn_d   = io.ctrl;
          a_neg_d = a_neg_in;
          b_neg_d = b_neg_in;
          dvsr_d  = b_mag;
          quo_d   = a_mag;
          rem_d   = '0;
          cnt_d   = '0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
          zflag_d = b_zero;
          // Same magnitudes the full restoring pass would leave behind for B == 0.
          if (b_zero) begin
            quo_d = '1;
            rem_d = a_mag;
          end
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (borrow) begin
          rem_d = shifted[n-1:0];
          quo_d = {quo_q[n-2:0], 1'b0};
        end else begin
          rem_d = diff;
          quo_d = {quo_q[n-2:0], 1'b1};
        end
      end
      FIX: begin
        q_d = (sgn_q & (a_neg_q ^ b_neg_q)) ? neg(quo_q) : quo_q;
        r_d = (sgn_q & a_neg_q) ? neg(rem_q) : rem_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
        dbz_d = zflag_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dvsr_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      zflag_q <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      dvsr_q  <= dvsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      zflag_q <= zflag_d;
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign io.Q = q_q;
  assign io.R = r_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  assign io.div_by_zero = dbz_q;
`else
  assign io.div_by_zero = 1'b0;
`endif
endmodule
